// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync preamble, then data MSB-first, then an idle gap.
// Ports: clk, reset_n, din/din_valid/din_ready (word in), bit_en (slot strobe), x/x_valid/busy/frame_done (out).
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 3,
  parameter logic [PRE_W-1:0]  PREAMBLE = 3'b011,
  parameter int                GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              bit_en,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int L    = PRE_W + DATA_W;
  localparam int M1   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAXV = (M1 > GAP_BITS) ? M1 : GAP_BITS;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int GM1  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_W - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GM1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  sr_q, sr_d;
  logic          x_q, x_d;
  logic          xv_q, xv_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
    end
  end

  // sr_q holds the bits still to send after the one on x,
  // so preamble and data share a single shift path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    x_d     = x_q;
    xv_d    = xv_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          state_d = PRE;
          cnt_d   = '0;
          sr_d    = {PREAMBLE, din} << 1;
          x_d     = PREAMBLE[PRE_W-1];
          xv_d    = 1'b1;
        end
      end
      PRE: begin
        if (bit_en) begin
          x_d  = sr_q[L-1];
          sr_d = sr_q << 1;
          if (cnt_q == PRE_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (bit_en) begin
          sr_d = sr_q << 1;
          if (cnt_q == DAT_LAST) begin
            cnt_d = '0;
            x_d   = 1'b0;
            xv_d  = 1'b0;
            if (GAP_BITS > 0) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            x_d   = sr_q[L-1];
          end
        end
      end
      GAP: begin
        if (bit_en) begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        x_d     = 1'b0;
        xv_d    = 1'b0;
      end
    endcase
  end

  assign x          = x_q;
  assign x_valid    = xv_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);
  assign din_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: GAP_BITS=2 and GAP_BITS=0 instances
// driven in parallel, checked against a frame-level model.
module tb_seq_frame_tx;

  localparam int         DW  = 8;
  localparam int         PW  = 3;
  localparam logic [2:0] PRE = 3'b011;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       bit_en = 1'b0;

  logic a_rdy, a_x, a_xv, a_busy, a_done;
  logic b_rdy, b_x, b_xv, b_busy, b_done;

  always #5 clk = ~clk;

  seq_frame_tx #(.DATA_W(8), .PRE_W(3), .PREAMBLE(3'b011), .GAP_BITS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(a_rdy), .bit_en(bit_en), .x(a_x), .x_valid(a_xv),
    .busy(a_busy), .frame_done(a_done)
  );

  seq_frame_tx #(.DATA_W(8), .PRE_W(3), .PREAMBLE(3'b011), .GAP_BITS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(b_rdy), .bit_en(bit_en), .x(b_x), .x_valid(b_xv),
    .busy(b_busy), .frame_done(b_done)
  );

  typedef struct packed {
    logic x;
    logic xv;
    logic busy;
    logic rdy;
    logic done;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // frame-level model: a frame is a list of slots indexed 0..total-1
  int         m_gap[2];
  bit         m_busy[2];
  int         m_idx[2];
  logic [7:0] m_word[2];
  bit         m_done[2];

  function automatic logic slot_bit(int m, int i);
    logic [2:0] p;
    logic [7:0] w;
    p = PRE;
    w = m_word[m];
    if (i < PW) return p[PW-1-i];
    if (i < PW + DW) return w[DW-1-(i-PW)];
    return 1'b0;
  endfunction

  function automatic obs_t expect_of(int m);
    obs_t e;
    e.x    = m_busy[m] ? slot_bit(m, m_idx[m]) : 1'b0;
    e.xv   = m_busy[m] && (m_idx[m] < PW + DW);
    e.busy = m_busy[m];
    e.rdy  = !m_busy[m];
    e.done = m_done[m];
    return e;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0;
      m_idx[m]  = 0;
      m_word[m] = 8'h00;
      m_done[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      m_done[m] = 1'b0;
      if (!reset_n) begin
        m_busy[m] = 1'b0;
        m_idx[m]  = 0;
        m_word[m] = 8'h00;
      end else if (!m_busy[m]) begin
        if (din_valid) begin
          m_busy[m] = 1'b1;
          m_idx[m]  = 0;
          m_word[m] = din;
        end
      end else if (bit_en) begin
        m_idx[m] = m_idx[m] + 1;
        if (m_idx[m] == PW + DW + m_gap[m]) begin
          m_busy[m] = 1'b0;
          m_idx[m]  = 0;
          m_done[m] = 1'b1;
        end
      end
    end
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    started = 1'b1;
  endtask

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {x,xv,busy,rdy,done}=%b expected %b",
               nm, $time, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (started) begin
      if (qa.size() == 0 || qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow @%0t", $time);
      end else begin
        chk("dut_gap2", {a_x, a_xv, a_busy, a_rdy, a_done}, qa.pop_front());
        chk("dut_gap0", {b_x, b_xv, b_busy, b_rdy, b_done}, qb.pop_front());
      end
    end
  end

  // loopback 011 detector on dut_a, sampling each bit slot
  logic [2:0] det_q;
  int         ycnt = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_q <= 3'b000;
    end else if (bit_en) begin
      det_q <= {det_q[1:0], a_x};
      if ({det_q[1:0], a_x} == 3'b011) ycnt <= ycnt + 1;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic be);
    @(posedge clk);
    #1;
    model_step();
    din_valid = v;
    din       = d;
    bit_en    = be;
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int y0;

  initial begin
    m_gap[0] = 2;
    m_gap[1] = 0;
    model_clear();

    // reset state
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    reset_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);

    // basic frame, bit_en tied high
    cyc(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'($urandom), 1'b1);

    // paced bits, one strobe in four
    cyc(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 60; i++) cyc(1'b0, 8'($urandom), 1'((i % 4) == 3));

    // loopback through the detector
    y0 = ycnt;
    for (int f = 0; f < 2; f++) begin
      cyc(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk_val("loopback_00", ycnt - y0, 2);
    y0 = ycnt;
    for (int f = 0; f < 2; f++) begin
      cyc(1'b1, 8'h33, 1'b1);
      for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk_val("loopback_33", ycnt - y0, 6);

    // back-to-back with din_valid held high, din churning while busy
    cyc(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'($urandom), 1'b1);

    // reset during data bit 4
    cyc(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'($urandom), 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_a", {a_x, a_xv, a_busy, a_rdy, a_done}, 5'b00010);
    chk("async_rst_b", {b_x, b_xv, b_busy, b_rdy, b_done}, 5'b00010);
    model_clear();
    qa.delete();
    qb.delete();
    qa.push_back(expect_of(0));
    qb.push_back(expect_of(1));
    cyc(1'b0, 8'h00, 1'b1);
    reset_n = 1'b1;
    cyc(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'($urandom), 1'b1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(1'(($urandom % 3) == 0), 8'($urandom),
          1'(($urandom % 4) != 0));
    end

    @(negedge clk);
    #1;
    chk_val("queue_drained", qa.size() + qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
